// File: rtl/lsu_pkg.sv
// Shared types, FSM state codes, funct3 codes and the access legality check
// for the load/store memory master.
package lsu_pkg;

    typedef logic [2:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE  = 3'd0;
    localparam lsu_state_t ST_RD    = 3'd1;
    localparam lsu_state_t ST_CAP   = 3'd2;
    localparam lsu_state_t ST_MERGE = 3'd3;
    localparam lsu_state_t ST_WR    = 3'd4;
    localparam lsu_state_t ST_DONE  = 3'd5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Unsigned loads have no store counterpart; the range bound is word-sized
    // regardless of access width.
    function automatic logic lsu_access_err(
        input logic        we,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input logic [31:0] addr_max
    );
        logic bad_f3;
        logic misal;
        bad_f3 = 1'b0;
        misal  = 1'b0;
        case (funct3)
            F3_B: begin
                bad_f3 = 1'b0;
                misal  = 1'b0;
            end
            F3_H: misal = addr[0];
            F3_W: misal = (addr[1:0] != 2'b00);
            F3_BU: bad_f3 = we;
            F3_HU: begin
                bad_f3 = we;
                misal  = addr[0];
            end
            default: bad_f3 = 1'b1;
        endcase
        return bad_f3 | misal | (addr > addr_max);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and lane replacement
// of a read word for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword lanes of the read word.
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        if (i_addr_lo[1]) begin
            w_half = i_rdata[31:16];
        end else begin
            w_half = i_rdata[15:0];
        end
    end

    // Extend the selected lane to the full load result.
    always_comb begin
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_load_data = i_rdata;
            F3_BU:   o_load_data = {24'h000000, w_byte};
            F3_HU:   o_load_data = {16'h0000, w_half};
            default: o_load_data = 32'h0000_0000;
        endcase
    end

    // Replace only the target lane; untouched lanes come from the read word.
    always_comb begin
        o_merge_data = i_rdata;
        case (i_funct3)
            F3_B: begin
                case (i_addr_lo)
                    2'd0:    o_merge_data = {i_rdata[31:8], i_wdata[7:0]};
                    2'd1:    o_merge_data = {i_rdata[31:16], i_wdata[7:0], i_rdata[7:0]};
                    2'd2:    o_merge_data = {i_rdata[31:24], i_wdata[7:0], i_rdata[15:0]};
                    2'd3:    o_merge_data = {i_wdata[7:0], i_rdata[23:0]};
                    default: o_merge_data = i_rdata;
                endcase
            end
            F3_H: begin
                if (i_addr_lo[1]) begin
                    o_merge_data = {i_wdata[15:0], i_rdata[15:0]};
                end else begin
                    o_merge_data = {i_rdata[31:16], i_wdata[15:0]};
                end
            end
            F3_W:    o_merge_data = i_wdata;
            default: o_merge_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator: one request at a time, registered-read memory,
// read-modify-write for sub-word stores, access errors reported without touching memory.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);

    lsu_state_t  r_state;
    lsu_req_t    r_req;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_err;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    assign w_accept = i_req_valid && o_req_ready;
    assign w_err    = lsu_access_err(i_req_we, i_req_funct3, i_req_addr, ADDR_MAX);

    lsu_align u_align (
        .i_funct3     (r_req.funct3),
        .i_addr_lo    (r_req.addr[1:0]),
        .i_rdata      (i_mem_rdata),
        .i_wdata      (r_req.wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    // Sequencer, request latch and response registers; reset drops any in-flight request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_req        <= '0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_req <= '{we: i_req_we, funct3: i_req_funct3,
                                   addr: i_req_addr, wdata: i_req_wdata};
                        if (w_err) begin
                            r_state      <= ST_DONE;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0000_0000;
                        end else if (i_req_we && (i_req_funct3 == F3_W)) begin
                            r_state <= ST_WR;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (r_req.we) begin
                        r_state <= ST_MERGE;
                    end else begin
                        r_state <= ST_CAP;
                    end
                end
                ST_CAP: begin
                    r_resp_rdata <= w_load_data;
                    r_resp_err   <= 1'b0;
                    r_state      <= ST_DONE;
                end
                ST_MERGE, ST_WR: begin
                    r_resp_rdata <= 32'h0000_0000;
                    r_resp_err   <= 1'b0;
                    r_state      <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory strobes come straight from state but are forced off while reset is high.
    assign o_req_ready  = (r_state == ST_IDLE) && !i_rst;
    assign o_resp_valid = (r_state == ST_DONE) && !i_rst;
    assign o_mem_read   = (r_state == ST_RD) && !i_rst;
    assign o_mem_write  = ((r_state == ST_WR) || (r_state == ST_MERGE)) && !i_rst;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

    // Word-aligned address whenever a request is in flight.
    always_comb begin
        if (i_rst || (r_state == ST_IDLE)) begin
            o_mem_addr = 32'h0000_0000;
        end else begin
            o_mem_addr = {r_req.addr[31:2], 2'b00};
        end
    end

    // Full-word write data: merged word for RMW, raw store data for SW.
    always_comb begin
        if (!o_mem_write) begin
            o_mem_wdata = 32'h0000_0000;
        end else if (r_state == ST_MERGE) begin
            o_mem_wdata = w_merge_data;
        end else begin
            o_mem_wdata = r_req.wdata;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized and directed bench for lsu_mem_master against a byte-array
// reference model of the memory and the access rules.
module tb_lsu_mem_master;

    localparam int MEM_BYTES = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] bmem [0:1023];
    logic [7:0]  ref_mem [0:MEM_BYTES-1];
    logic        mem_init;

    lsu_mem_master #(.MEM_BYTES(MEM_BYTES)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_f3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_resp_valid (resp_valid),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    // Memory with one-cycle registered read and full-word write.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) bmem[i] <= pat(i);
            mem_rdata <= 32'h0;
        end else begin
            if (mem_write) bmem[mem_addr[11:2]] <= mem_wdata;
            if (mem_read) mem_rdata <= bmem[mem_addr[11:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        int   sz;
        if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        sz = acc_size(f3);
        if (!legal) return 1'b1;
        if (a % 32'(sz) != 32'd0) return 1'b1;
        return a > 32'(MEM_BYTES - 4);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int sz;
        sz = acc_size(f3);
        v = 32'h0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[int'(a[11:0]) + i];
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ((sz == 1) ? 32'hFFFF_FF00 : 32'hFFFF_0000);
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[int'({a[11:2], 2'b00}) + i];
        return v;
    endfunction

    // Drive one request and check the whole transaction timing and results.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd_out, output logic err_out);
        logic        exp_err;
        logic [31:0] exp_rd, exp_wword, got_rd, got_wd, got_wa, got_ra;
        logic        got_err;
        int          rd_c, wr_c, rv_c, e_rd, e_wr, e_rv, sz;
        @(negedge clk);
        chk("ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
        exp_err = ref_err(we, f3, a);
        exp_rd = 32'h0; exp_wword = 32'h0;
        if (exp_err) begin
            e_rd = 0; e_wr = 0; e_rv = 1;
        end else if (!we) begin
            exp_rd = ref_load(f3, a);
            e_rd = 1; e_wr = 0; e_rv = 3;
        end else begin
            sz = acc_size(f3);
            for (int i = 0; i < sz; i++) ref_mem[int'(a[11:0]) + i] = wd[8*i +: 8];
            exp_wword = ref_word(a);
            if (sz == 4) begin e_rd = 0; e_wr = 1; e_rv = 2; end
            else begin e_rd = 1; e_wr = 2; e_rv = 3; end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        rd_c = 0; wr_c = 0; rv_c = 0;
        got_rd = 32'h0; got_wd = 32'h0; got_wa = 32'h0; got_ra = 32'h0; got_err = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (mem_read && rd_c == 0) begin rd_c = c; got_ra = mem_addr; end
            if (mem_write && wr_c == 0) begin wr_c = c; got_wa = mem_addr; got_wd = mem_wdata; end
            if (resp_valid) begin rv_c = c; got_rd = resp_rdata; got_err = resp_err; break; end
        end
        chk("resp_cycle", rv_c, e_rv);
        chk("read_cycle", rd_c, e_rd);
        chk("write_cycle", wr_c, e_wr);
        chk("resp_err", got_err, exp_err);
        chk("resp_rdata", got_rd, exp_rd);
        if (e_rd != 0) chk("read_addr", got_ra, {a[31:2], 2'b00});
        if (e_wr != 0) begin
            chk("write_addr", got_wa, {a[31:2], 2'b00});
            chk("write_data", got_wd, exp_wword);
        end
        @(negedge clk);
        chk("resp_pulse", resp_valid, 1'b0);
        chk("ready_after", req_ready, 1'b1);
        chk("hold_rdata", resp_rdata, exp_rd);
        chk("hold_err", resp_err, exp_err);
        rd_out = got_rd;
        err_out = got_err;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r, w, a;
        logic        e;
        int          n_rv, rv1, rv2, acc_c, nwr, nrd;
        logic [31:0] rd2;

        rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0;
        req_we = 1'b0; req_f3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            w = pat(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", resp_err, 1'b0);
        chk("rst_mem_rd", mem_read, 1'b0);
        chk("rst_mem_wr", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        mem_init = 1'b0;
        rst = 1'b0;

        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, r, e);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, r, e);
        chk("tp_lw_10", r, 32'hDEAD_BEEF);
        do_req(1'b1, 3'd2, 32'h20, 32'h1122_3344, r, e);
        do_req(1'b1, 3'd0, 32'h22, 32'h0000_00AA, r, e);
        do_req(1'b0, 3'd0, 32'h22, 32'h0, r, e);
        chk("tp_lb_22", r, 32'hFFFF_FFAA);
        do_req(1'b0, 3'd4, 32'h22, 32'h0, r, e);
        chk("tp_lbu_22", r, 32'h0000_00AA);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, r, e);
        chk("tp_sb_word", r, 32'h11AA_3344);
        do_req(1'b1, 3'd2, 32'h40, 32'h8001_7FFF, r, e);
        do_req(1'b0, 3'd1, 32'h42, 32'h0, r, e);
        chk("tp_lh_42", r, 32'hFFFF_8001);
        do_req(1'b0, 3'd5, 32'h40, 32'h0, r, e);
        chk("tp_lhu_40", r, 32'h0000_7FFF);
        do_req(1'b1, 3'd1, 32'h42, 32'h0000_1234, r, e);
        do_req(1'b0, 3'd2, 32'h40, 32'h0, r, e);
        chk("tp_sh_word", r, 32'h1234_7FFF);
        do_req(1'b0, 3'd2, 32'h13, 32'h0, r, e);
        chk("tp_err_lw13", e, 1'b1);
        do_req(1'b0, 3'd1, 32'h41, 32'h0, r, e);
        chk("tp_err_lh41", e, 1'b1);
        do_req(1'b1, 3'd2, 32'hFFD, 32'h5555_5555, r, e);
        chk("tp_err_swffd", e, 1'b1);
        do_req(1'b0, 3'd3, 32'h0, 32'h0, r, e);
        chk("tp_err_f3_011", e, 1'b1);

        // Reset during the MERGE cycle of an SB: memory must stay untouched.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd0; req_addr = 32'h20; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_read", mem_read, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_write", mem_write, 1'b0);
        chk("mid_rst_rv", resp_valid, 1'b0);
        chk("mid_rst_ready", req_ready, 1'b0);
        @(negedge clk);
        chk("mid_rst_rv2", resp_valid, 1'b0);
        chk("mid_rst_write2", mem_write, 1'b0);
        chk("mid_rst_err", resp_err, 1'b0);
        chk("mid_rst_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_back", req_ready, 1'b1);
        chk("mid_rst_rv3", resp_valid, 1'b0);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, r, e);
        chk("mid_rst_mem", r, 32'h11AA_3344);

        // SW then LW with req_valid held continuously.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd2; req_addr = 32'h80; req_wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) ref_mem[32'h80 + i] = req_wdata[8*i +: 8];
        @(posedge clk);
        #1 begin req_we = 1'b0; req_wdata = 32'h0; end
        n_rv = 0; rv1 = 0; rv2 = 0; acc_c = 0; nwr = 0; nrd = 0; rd2 = 32'h0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (mem_write) nwr++;
            if (mem_read) nrd++;
            if (resp_valid) begin
                n_rv++;
                if (n_rv == 1) rv1 = c;
                else begin rv2 = c; rd2 = resp_rdata; end
            end
            if (req_valid && req_ready) begin
                acc_c = c;
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        chk("b2b_resp_count", n_rv, 2);
        chk("b2b_first_resp", rv1, 2);
        chk("b2b_accept", acc_c, 3);
        chk("b2b_second_resp", rv2, 6);
        chk("b2b_rdata", rd2, 32'hCAFE_F00D);
        chk("b2b_writes", nwr, 1);
        chk("b2b_reads", nrd, 1);

        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = $urandom_range(0, 15);
            if (sel == 0) a = $urandom;
            else if (sel == 1) a = 32'(4088 + $urandom_range(0, 7));
            else a = 32'($urandom_range(0, 255));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, r, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
